// File: rtl/lava_pkg.sv
// Shared types and instruction-word field helpers for the LAVA sequencer.
package lava_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wide carrier types let the field helpers serve any DATA_W/LANES/OP_W;
  // callers cast the result down to the real field width.
  localparam int MAX_WORD_W  = 512;
  localparam int MAX_FIELD_W = 64;

  // Default terminating opcode: all ones at whatever width the caller uses.
  localparam logic [MAX_FIELD_W-1:0] HALT_OP_DEFAULT = '1;

  function automatic logic [MAX_FIELD_W-1:0] field_mask(input int w);
    return (MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1);
  endfunction

  // Opcode sits above all lane operand pairs.
  function automatic logic [MAX_FIELD_W-1:0] word_op(input logic [MAX_WORD_W-1:0] word,
                                                     input int data_w, input int lanes,
                                                     input int op_w);
    return MAX_FIELD_W'(word >> (lanes * 2 * data_w)) & field_mask(op_w);
  endfunction

  // Each lane is {a,b}: a in the upper half of the lane slot.
  function automatic logic [MAX_FIELD_W-1:0] word_a(input logic [MAX_WORD_W-1:0] word,
                                                    input int lane, input int data_w);
    return MAX_FIELD_W'(word >> (lane * 2 * data_w + data_w)) & field_mask(data_w);
  endfunction

  function automatic logic [MAX_FIELD_W-1:0] word_b(input logic [MAX_WORD_W-1:0] word,
                                                    input int lane, input int data_w);
    return MAX_FIELD_W'(word >> (lane * 2 * data_w)) & field_mask(data_w);
  endfunction

endpackage

// File: rtl/lava_seq_inflight.sv
// Valid delay line matching the ALU latency; its tail is the RAM write strobe.
module lava_inflight #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  output logic valid_out,
  output logic any_pending
);

  // Every stage except the output one: results that still have to land later.
  localparam logic [DEPTH-1:0] EARLY_MASK = (DEPTH'(1) << (DEPTH - 1)) - DEPTH'(1);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  assign stage_next[0] = valid_in;
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  // Shift the valid bits one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_reg <= '0;
    else     stage_reg <= stage_next;
  end

  assign valid_out   = stage_reg[DEPTH-1];
  // High while some issued result has not yet reached the write stage.
  assign any_pending = valid_in | (|(stage_reg & EARLY_MASK));

endmodule

// File: rtl/lava_seq.sv
// LAVA sequencer: fetches packed words, issues them to a pipelined ALU and
// writes each result to RAM ALU_LAT cycles after issue.
module lava_seq
  import lava_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LANES   = 2,
  parameter int OP_W    = 4,
  parameter int ADDR_W  = 3,
  parameter int WADDR_W = 3,
  parameter int ALU_LAT = 2,
  parameter logic [OP_W-1:0] HALT_OP = OP_W'(HALT_OP_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W:0]               prog_len,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [OP_W+LANES*2*DATA_W-1:0] rom_data,
  output logic [OP_W-1:0]               alu_op,
  output logic [LANES*DATA_W-1:0]       alu_a,
  output logic [LANES*DATA_W-1:0]       alu_b,
  output logic                          alu_valid,
  input  logic [LANES*DATA_W-1:0]       alu_result,
  output logic                          ram_we,
  output logic [WADDR_W-1:0]            ram_addr,
  output logic [LANES*DATA_W-1:0]       ram_wdata,
  output logic                          busy,
  output logic                          done
);

  state_t                  state_reg, state_next;
  logic [ADDR_W:0]         count_reg;
  logic [ADDR_W:0]         len_reg;
  logic [WADDR_W-1:0]      wptr_reg;
  logic                    issue_ok;
  logic                    any_pending;
  logic [MAX_WORD_W-1:0]   rom_word_ext;
  logic [OP_W-1:0]         cur_op;
  logic [LANES*DATA_W-1:0] cur_a;
  logic [LANES*DATA_W-1:0] cur_b;

  // Field extraction of the current ROM word.
  assign rom_word_ext = MAX_WORD_W'(rom_data);
  assign cur_op       = OP_W'(word_op(rom_word_ext, DATA_W, LANES, OP_W));
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign cur_a[gi*DATA_W +: DATA_W] = DATA_W'(word_a(rom_word_ext, gi, DATA_W));
      assign cur_b[gi*DATA_W +: DATA_W] = DATA_W'(word_b(rom_word_ext, gi, DATA_W));
    end
  endgenerate

  // A word issues only while words remain and it is not the HALT word.
  assign issue_ok = (count_reg < len_reg) && (cur_op != HALT_OP);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (prog_len == '0) ? DONE : ISSUE;
      ISSUE: if (!issue_ok) state_next = DRAIN;
      DRAIN: if (!any_pending) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      IDLE:    busy = 1'b0;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

  // Fetch pointer, issue registers and write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      count_reg <= '0;
      len_reg   <= '0;
      wptr_reg  <= '0;
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      alu_valid <= 1'b0;
      if (ram_we) wptr_reg <= wptr_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            rom_addr  <= '0;
            count_reg <= '0;
            len_reg   <= prog_len;
            wptr_reg  <= '0;
          end
        end
        ISSUE: begin
          if (issue_ok) begin
            alu_valid <= 1'b1;
            alu_op    <= cur_op;
            alu_a     <= cur_a;
            alu_b     <= cur_b;
            rom_addr  <= rom_addr + 1'b1;
            count_reg <= count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  lava_inflight #(
    .DEPTH(ALU_LAT)
  ) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (alu_valid),
    .valid_out  (ram_we),
    .any_pending(any_pending)
  );

  assign ram_addr  = wptr_reg;
  assign ram_wdata = alu_result;

endmodule
